// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared FSM state type and ALU opcode constants for alu_arbiter
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_SLL   = 2;
  localparam int OP_SRL   = 3;
  localparam int OP_AND   = 4;
  localparam int OP_OR    = 5;
  localparam int OP_XOR   = 6;
  localparam int OP_SRA   = 7;
  localparam int OP_SLT   = 8;
  localparam int OP_SLTU  = 9;
  localparam int OP_ADDI  = 10;
  localparam int OP_ANDI  = 11;
  localparam int OP_ORI   = 12;
  localparam int OP_XORI  = 13;
  localparam int OP_SLLI  = 14;
  localparam int OP_SRLI  = 15;
  localparam int OP_SRAI  = 16;
  localparam int OP_SLTI  = 17;
  localparam int OP_SLTIU = 18;

  // Highest opcode the ALU implements; anything above it is reported as an error.
  localparam int MAX_OP = OP_SLTIU;

endpackage

// File: rtl/alu_arbiter_rr_grant.sv
// rtl/alu_arbiter_rr_grant.sv - two-way round-robin grant selection (combinational)
module rr_grant2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Sole requester wins; on contention ptr picks the requester (0 -> req0, 1 -> req1).
  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0] & (~valid[1] | ~ptr);
    grant[1] = valid[1] & (~valid[0] |  ptr);
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sequencing one operation at a time through an external registered ALU
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int MAX_OP = alu_arbiter_pkg::MAX_OP
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_data_in_1,
  output logic [DATA_W-1:0] alu_data_in_2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_data_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  import alu_arbiter_pkg::*;

  state_t     state;
  logic       rr_ptr;
  logic [1:0] grant;
  logic       can_accept;
  logic       accept;
  logic       op_illegal;

  rr_grant2 u_rr_grant2 (
    .valid ({req1_valid, req0_valid}),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Readies are only offered in IDLE and never while reset is held.
  assign can_accept = (state == IDLE) && !reset;
  assign req0_ready = can_accept && grant[0];
  assign req1_ready = can_accept && grant[1];
  assign accept     = can_accept && (grant != 2'b00);

  // The latched opcode already sits on alu_op, so legality is judged from it.
  assign op_illegal = (alu_op > OP_W'(MAX_OP));

  // Main FSM: latch on accept, drive ALU in ISSUE, capture in EXEC, hold response in RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      alu_data_in_1 <= '0;
      alu_data_in_2 <= '0;
      alu_op        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_data_in_1 <= grant[1] ? req1_a  : req0_a;
            alu_data_in_2 <= grant[1] ? req1_b  : req0_b;
            alu_op        <= grant[1] ? req1_op : req0_op;
            rsp_id        <= grant[1];
            rr_ptr        <= ~grant[1];
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          state <= EXEC;
        end
        EXEC: begin
          rsp_data  <= op_illegal ? '0 : alu_data_out;
          rsp_err   <= op_illegal;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking testbench for alu_arbiter
module tb_alu_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0]  req0_op, req1_op;
  logic [31:0] alu_data_in_1, alu_data_in_2;
  logic [5:0]  alu_op;
  logic [31:0] alu_data_out;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;

  int total = 0;
  int bad   = 0;

  alu_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req1_valid    (req1_valid),
    .req0_ready    (req0_ready),
    .req1_ready    (req1_ready),
    .req0_a        (req0_a),
    .req0_b        (req0_b),
    .req1_a        (req1_a),
    .req1_b        (req1_b),
    .req0_op       (req0_op),
    .req1_op       (req1_op),
    .alu_data_in_1 (alu_data_in_1),
    .alu_data_in_2 (alu_data_in_2),
    .alu_op        (alu_op),
    .alu_data_out  (alu_data_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
    case (op)
      6'd0, 6'd10:  return a + b;
      6'd1:         return a - b;
      6'd2, 6'd14:  return a << b[4:0];
      6'd3, 6'd15:  return a >> b[4:0];
      6'd4, 6'd11:  return a & b;
      6'd5, 6'd12:  return a | b;
      6'd6, 6'd13:  return a ^ b;
      6'd7, 6'd16:  return $signed(a) >>> b[4:0];
      6'd8, 6'd17:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd9, 6'd18:  return (a < b) ? 32'd1 : 32'd0;
      default:      return a ^ b ^ 32'hDEADBEEF;
    endcase
  endfunction

  // Environment ALU: registered, result valid one cycle after it samples its inputs.
  always @(posedge clock) alu_data_out <= alu_fn(alu_data_in_1, alu_data_in_2, alu_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Called just after the accept edge; walks ISSUE, EXEC, RESP and hands the response off.
  task automatic finish_rsp(input logic id, input logic [31:0] data, input logic err);
    @(negedge clock);
    check("issue_rsp_valid", 32'(rsp_valid), 32'd0);
    check("issue_readies", 32'({req1_ready, req0_ready}), 32'd0);
    tick();
    @(negedge clock);
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clock);
    check("resp_valid", 32'(rsp_valid), 32'd1);
    check("resp_id", 32'(rsp_id), 32'(id));
    check("resp_data", rsp_data, data);
    check("resp_err", 32'(rsp_err), 32'(err));
    rsp_ready = 1'b1;
    tick();
  endtask

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [5:0]  op0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [5:0]  op1;
    logic        exp_id;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl[9];

  int          q_grant[$];
  int          q_gcyc[$];
  logic [31:0] q_data[$];
  int          q_rid[$];
  int          q_rcyc[$];

  int          m_since;
  logic        m_ptr;
  logic        m_id;
  logic [31:0] m_data;
  logic        m_err;
  logic        want0, want1;

  initial begin
    // Reset values with both requesters pushing: readies must stay low.
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    req0_a = 32'd1; req0_b = 32'd1; req0_op = 6'd0;
    req1_a = 32'd1; req1_b = 32'd1; req1_op = 6'd0;
    tick();
    @(negedge clock);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_alu_in1", alu_data_in_1, 32'd0);
    check("rst_alu_in2", alu_data_in_2, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);

    // Table of single transactions; rr pointer evolves from 0 across the entries.
    tbl[0] = '{1'b1, 1'b0, 32'd5, 32'd3, 6'd0, 32'd0, 32'd0, 6'd0, 1'b0, 32'd8, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 32'd7, 32'd2, 6'd1, 32'd6, 32'd3, 6'd4, 1'b1, 32'd2, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'd7, 32'd2, 6'd1, 32'd6, 32'd3, 6'd4, 1'b0, 32'd5, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 32'd0, 32'd0, 6'd0, 32'd1, 32'd2, 6'd25, 1'b1, 32'd0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 32'd0, 32'd0, 6'd0, 32'd9, 32'd4, 6'd0, 1'b1, 32'd13, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'd1, 6'd0, 32'd3, 32'd3, 6'd5, 1'b0, 32'd0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 32'd1, 32'd2, 6'd18, 32'd0, 32'd0, 6'd0, 1'b0, 32'd1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 32'd0, 32'd0, 6'd0, 32'd4, 32'd4, 6'd19, 1'b1, 32'd0, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 32'h80000000, 32'd1, 6'd8, 32'd1, 32'd1, 6'd1, 1'b0, 32'd1, 1'b0};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      req0_valid = tbl[i].v0; req0_a = tbl[i].a0; req0_b = tbl[i].b0; req0_op = tbl[i].op0;
      req1_valid = tbl[i].v1; req1_a = tbl[i].a1; req1_b = tbl[i].b1; req1_op = tbl[i].op1;
      rsp_ready = 1'b1;
      @(negedge clock);
      check($sformatf("tbl%0d_req0_ready", i), 32'(req0_ready), 32'(tbl[i].exp_id == 1'b0));
      check($sformatf("tbl%0d_req1_ready", i), 32'(req1_ready), 32'(tbl[i].exp_id == 1'b1));
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      check($sformatf("tbl%0d_alu_in1", i), alu_data_in_1, tbl[i].exp_id ? tbl[i].a1 : tbl[i].a0);
      check($sformatf("tbl%0d_alu_op", i), 32'(alu_op), 32'(tbl[i].exp_id ? tbl[i].op1 : tbl[i].op0));
      finish_rsp(tbl[i].exp_id, tbl[i].exp_data, tbl[i].exp_err);
    end

    // Both requesters held valid from reset: grants alternate, one op per 4 cycles.
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd2; req0_op = 6'd1;
    req1_valid = 1'b1; req1_a = 32'd6; req1_b = 32'd3; req1_op = 6'd4;
    rsp_ready = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (req0_ready) begin q_grant.push_back(0); q_gcyc.push_back(c); end
      if (req1_ready) begin q_grant.push_back(1); q_gcyc.push_back(c); end
      if (rsp_valid) begin q_data.push_back(rsp_data); q_rid.push_back(int'(rsp_id)); q_rcyc.push_back(c); end
      tick();
    end
    check("alt_grant_count", 32'(q_grant.size()), 32'd3);
    check("alt_rsp_count", 32'(q_data.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < q_grant.size()) begin
        check($sformatf("alt_grant%0d", i), 32'(q_grant[i]), 32'(i % 2));
        check($sformatf("alt_gcyc%0d", i), 32'(q_gcyc[i]), 32'(4 * i));
      end
      if (i < q_data.size()) begin
        check($sformatf("alt_data%0d", i), q_data[i], (i % 2 == 1) ? 32'd2 : 32'd5);
        check($sformatf("alt_rid%0d", i), 32'(q_rid[i]), 32'(i % 2));
        check($sformatf("alt_rcyc%0d", i), 32'(q_rcyc[i]), 32'(4 * i + 3));
      end
    end

    // Response back-pressure for 5 cycles while both requesters push.
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4; req0_op = 6'd1;
    tick();
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_op = 6'd0;
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_data", rsp_data, 32'd6);
      check("stall_readies", 32'({req1_ready, req0_ready}), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    check("stall_release_valid", 32'(rsp_valid), 32'd1);
    tick();
    @(negedge clock);
    check("stall_after_valid", 32'(rsp_valid), 32'd0);
    check("stall_after_req1_ready", 32'(req1_ready), 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Reset during EXEC abandons the op; first edge after reset accepts with rr_ptr=0.
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd11; req0_b = 32'd1; req0_op = 6'd0;
    tick();
    req0_valid = 1'b0;
    tick();
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_op = 6'd0;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_op = 6'd0;
    @(negedge clock);
    check("rexec_readies", 32'({req1_ready, req0_ready}), 32'd0);
    check("rexec_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rexec_rsp_valid2", 32'(rsp_valid), 32'd0);
    check("rexec_rsp_data", rsp_data, 32'd0);
    check("rexec_rsp_id", 32'(rsp_id), 32'd0);
    check("rexec_alu_in1", alu_data_in_1, 32'd0);
    check("rexec_alu_op", 32'(alu_op), 32'd0);
    check("rexec_req0_ready", 32'(req0_ready), 32'd1);
    check("rexec_req1_ready", 32'(req1_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    finish_rsp(1'b0, 32'd7, 1'b0);

    // req0 pulses for one cycle during ISSUE and must never be accepted.
    do_reset();
    rsp_ready = 1'b1;
    req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd5; req1_op = 6'd1;
    @(negedge clock);
    check("pulse_req1_ready", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 6'd0;
    @(negedge clock);
    check("pulse_req0_ready", 32'(req0_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    @(negedge clock);
    check("pulse_exec_valid", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clock);
    check("pulse_rsp_valid", 32'(rsp_valid), 32'd1);
    check("pulse_rsp_id", 32'(rsp_id), 32'd1);
    check("pulse_rsp_data", rsp_data, 32'd15);
    tick();
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      check("pulse_no_extra_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end

    // Random traffic against a transaction-level model.
    do_reset();
    m_since = -1;
    m_ptr = 1'b0;
    m_id = 1'b0; m_data = '0; m_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = $urandom(); req0_b = $urandom(); req0_op = 6'($urandom_range(0, 22));
      req1_a = $urandom(); req1_b = $urandom(); req1_op = 6'($urandom_range(0, 22));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      want1 = (m_since < 0) && req1_valid && (!req0_valid || m_ptr);
      want0 = (m_since < 0) && req0_valid && !want1;
      check("rnd_req0_ready", 32'(req0_ready), 32'(want0));
      check("rnd_req1_ready", 32'(req1_ready), 32'(want1));
      check("rnd_rsp_valid", 32'(rsp_valid), 32'(m_since == 2));
      if (m_since == 2) begin
        check("rnd_rsp_id", 32'(rsp_id), 32'(m_id));
        check("rnd_rsp_data", rsp_data, m_data);
        check("rnd_rsp_err", 32'(rsp_err), 32'(m_err));
      end
      if (want0 || want1) begin
        m_id = want1;
        m_err = want1 ? (req1_op > 6'd18) : (req0_op > 6'd18);
        m_data = m_err ? 32'd0 :
                 (want1 ? alu_fn(req1_a, req1_b, req1_op) : alu_fn(req0_a, req0_b, req0_op));
        m_ptr = !want1;
        m_since = 0;
      end else if (m_since >= 0 && m_since < 2) begin
        m_since++;
      end else if (m_since == 2 && rsp_ready) begin
        m_since = -1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
